t02_bus_arbiter: RTL and testbench
==================================

// Module: t02_bus_arbiter
// PURPOSE
//  Shares the single t02_wishbone_manager request port among NUM_REQ CPU-side requesters
//  (req 0 = instruction fetch, req 1 = data load/store).
//  Arbitration is round-robin. One transaction at a time: latch the winner, drive the manager, wait for completion, then ack.
//  Sits between t02_top memory ports and t02_wishbone_manager inside team_02.
// PARAMETERS
//  NUM_REQ    2    number of requesters (2..4)
//  TIMEOUT    255  cycles of mgr_busy before abort (T02_ARB_TIMEOUT_EN only; 8-bit counter)
// PORTS
//  clk         in   1            system clock
//  rst         in   1            synchronous, active-high reset
//  en          in   1            block enable; low = no new grants
//  req_valid   in   NUM_REQ      per-requester request, held until its ack
//  req_we      in   NUM_REQ      1 = write, 0 = read
//  req_addr    in   32*NUM_REQ   packed byte addresses, req i at [32i+:32]
//  req_wdata   in   32*NUM_REQ   packed write data
//  req_sel     in   4*NUM_REQ    packed byte selects
//  req_ack     out  NUM_REQ      one-cycle completion pulse to granted requester
//  req_rdata   out  32           read data, valid in the req_ack cycle
//  req_err     out  1            abort flag, pulses with req_ack (0 when macro absent)
//  grant_id    out  2            index of current/last granted requester
//  mgr_adr     out  32           to manager ADR_I
//  mgr_wdata   out  32           to manager CPU_DAT_I
//  mgr_sel     out  4            to manager SEL_I
//  mgr_write   out  1            to manager WRITE_I
//  mgr_read    out  1            to manager READ_I
//  mgr_rdata   in   32           from manager CPU_DAT_O
//  mgr_busy    in   1            from manager BUSY_O
// BEHAVIOUR
//  Reset (sync, rst=1 at posedge): state=IDLE, all outputs 0, rr pointer=0, grant_id=0.
//  FSM: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//  IDLE: if en and any req_valid, pick the first set bit at or after (rr+1) mod NUM_REQ.
//   Latch its addr/wdata/sel/we into registers, set grant_id, then go to ISSUE. Registered; no combinational req->mgr path.
//  ISSUE: assert mgr_read (we=0) or mgr_write (we=1) from latched data.
//   Hold it until mgr_busy=1 is sampled, then go to WAIT and drop read/write that same cycle.
//  WAIT: when mgr_busy=0, capture mgr_rdata into req_rdata, then go to DONE.
//  DONE: req_ack[grant_id]=1 for exactly one cycle; rr<=grant_id; -> IDLE.
//  req_rdata holds its value until the next capture. Writes leave it unchanged.
//  Latency from request to ack is 3 + manager busy cycles.
//  Re-arbitration happens only in IDLE, so the earliest next grant is the cycle after DONE.
//  Simultaneous requests: round-robin fairness, so no requester waits more than NUM_REQ-1 transactions.
//  Deasserting req_valid after the grant is ignored; the transaction completes and acks.
//  en low mid-transaction: the transaction finishes; no new grant.
//  rst mid-transaction: the FSM returns to IDLE at once and mgr_read/mgr_write drop.
//   No ack is issued, so requesters must reissue.
//  mgr_read and mgr_write are never both 1. At most one req_ack bit is set.
// CONFIGURATION
//  T02_ARB_TIMEOUT_EN defined:
//   - ISSUE+WAIT cycles are counted. At TIMEOUT: force read/write low, go to DONE with req_err=1, req_rdata=32'hDEAD_BEEF.
//  Absent:
//   - no counter; waits forever on mgr_busy; req_err tied 0.
// STRUCTURE
//  Package t02_bus_pkg:
//   - arb_state_t enum {IDLE, ISSUE, WAIT, DONE}
//   - ARB_ERR_DATA = 32'hDEAD_BEEF
//   - MAX_REQ = 4
//  Sub-module t02_rr_picker: combinational round-robin select (req vector, rr pointer -> index, found).
// TESTING
//  1 single read: req_valid=01, addr=0x33000010; manager busy 4 cycles, rdata=0x12345678
//    -> mgr_read rises 1 cycle later; req_ack=01 with req_rdata=0x12345678 at cycle 8.
//  2 contention: req_valid=11 held from reset, rr=0
//    -> grants 1,0,1,0 in order; each ack one cycle; mgr_read and mgr_write never both high.
//  3 write: req1 we=1, wdata=0xA5A5A5A5, sel=4'hF
//    -> mgr_write=1 with mgr_wdata=0xA5A5A5A5; req_ack=10; req_rdata unchanged.
//  4 reset mid-WAIT: rst=1 for one cycle
//    -> next cycle all outputs 0, state IDLE, no ack.
//  5 en=0 with req_valid=01 -> no mgr_read; raise en -> grant within 1 cycle.
//  6 (T02_ARB_TIMEOUT_EN, TIMEOUT=8) mgr_busy stuck at 1
//    -> req_ack plus req_err at cycle 10; req_rdata=0xDEADBEEF.

Source files
------------

// File: rtl/t02_bus_pkg.sv
// Shared types and constants for the team_02 bus arbiter and its round-robin picker.
package t02_bus_pkg;

    localparam int          MAX_REQ      = 4;
    localparam logic [31:0] ARB_ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;

    typedef logic [$clog2(MAX_REQ)-1:0] req_idx_t;

    // Distance of requester idx from the slot just after the rr pointer, modulo n.
    function automatic int rr_dist(input int idx, input int rr, input int n);
        return (idx + 2 * n - rr - 1) % n;
    endfunction

endpackage

// File: rtl/t02_rr_picker.sv
// Combinational round-robin select: first set request at or after (rr+1) mod NUM_REQ.
module t02_rr_picker
    import t02_bus_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  req_idx_t           i_rr,
    output req_idx_t           o_idx,
    output logic               o_found
);

    int w_best;

    always_comb begin
        // NOTE: every output is defaulted before the loop, so no latch can be inferred.
        o_idx   = '0;
        o_found = 1'b0;
        w_best  = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i_req[i] && (rr_dist(i, int'(i_rr), NUM_REQ) < w_best)) begin
                w_best  = rr_dist(i, int'(i_rr), NUM_REQ);
                o_idx   = req_idx_t'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/t02_bus_arbiter.sv
// Round-robin arbiter sharing the t02_wishbone_manager port among NUM_REQ requesters.
// Define T02_ARB_TIMEOUT_EN to abort transactions whose manager stays busy for TIMEOUT cycles.
module t02_bus_arbiter
    import t02_bus_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_we,
    input  logic [32*NUM_REQ-1:0] req_addr,
    input  logic [32*NUM_REQ-1:0] req_wdata,
    input  logic [4*NUM_REQ-1:0]  req_sel,
    output logic [NUM_REQ-1:0]    req_ack,
    output logic [31:0]           req_rdata,
    output logic                  req_err,
    output logic [1:0]            grant_id,
    output logic [31:0]           mgr_adr,
    output logic [31:0]           mgr_wdata,
    output logic [3:0]            mgr_sel,
    output logic                  mgr_write,
    output logic                  mgr_read,
    input  logic [31:0]           mgr_rdata,
    input  logic                  mgr_busy
);

    arb_state_t  r_state, w_state_nxt;
    req_idx_t    r_rr, r_grant, w_pick;
    logic        w_found, w_start, w_timeout, w_we;
    logic        r_we, r_err;
    logic [31:0] r_adr, r_wdata, r_rdata, w_adr, w_wdata;
    logic [3:0]  r_sel, w_sel;

    t02_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .i_req   (req_valid),
        .i_rr    (r_rr),
        .o_idx   (w_pick),
        .o_found (w_found)
    );

    assign w_start = en && w_found && (r_state == IDLE);

    // Winner's request fields, latched on grant so the manager never sees a live req path.
    always_comb begin
        w_adr   = '0;
        w_wdata = '0;
        w_sel   = '0;
        w_we    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick == req_idx_t'(i)) begin
                w_adr   = req_addr[32*i +: 32];
                w_wdata = req_wdata[32*i +: 32];
                w_sel   = req_sel[4*i +: 4];
                w_we    = req_we[i];
            end
        end
    end

`ifdef T02_ARB_TIMEOUT_EN
    logic [7:0] r_cnt;

    // A manager that drops busy on the final counted cycle completes normally.
    assign w_timeout = (r_cnt == 8'(TIMEOUT - 1)) &&
                       ((r_state == ISSUE) || ((r_state == WAIT) && mgr_busy));

    always_ff @(posedge clk) begin
        if (rst || (r_state == IDLE) || (r_state == DONE)) r_cnt <= '0;
        else                                               r_cnt <= r_cnt + 8'd1;
    end
`else
    logic w_unused_cfg;

    assign w_timeout    = 1'b0;
    assign w_unused_cfg = ^8'(TIMEOUT);
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start)   w_state_nxt = ISSUE;
            ISSUE:   if (mgr_busy)  w_state_nxt = WAIT;
            WAIT:    if (!mgr_busy) w_state_nxt = DONE;
            DONE:                   w_state_nxt = IDLE;
            default:                w_state_nxt = IDLE;
        endcase
        if (w_timeout) w_state_nxt = DONE;
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            r_state <= IDLE;
            r_rr    <= '0;
            r_grant <= '0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_adr   <= '0;
            r_wdata <= '0;
            r_sel   <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_grant <= w_pick;
                r_adr   <= w_adr;
                r_wdata <= w_wdata;
                r_sel   <= w_sel;
                r_we    <= w_we;
                r_err   <= 1'b0;
            end
            if (w_timeout) begin
                r_rdata <= ARB_ERR_DATA;
                r_err   <= 1'b1;
            end else if ((r_state == WAIT) && !mgr_busy && !r_we) begin
                r_rdata <= mgr_rdata;
            end
            if (r_state == DONE) r_rr <= r_grant;
        end
    end

    assign mgr_read  = (r_state == ISSUE) && !r_we;
    assign mgr_write = (r_state == ISSUE) && r_we;
    assign mgr_adr   = r_adr;
    assign mgr_wdata = r_wdata;
    assign mgr_sel   = r_sel;
    assign req_ack   = (r_state == DONE) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << r_grant) : '0;
    assign req_err   = (r_state == DONE) && r_err;
    assign req_rdata = r_rdata;
    assign grant_id  = r_grant;

endmodule

// File: tb/tb_t02_bus_arbiter.sv
// Self-checking bench for t02_bus_arbiter: vector table, scoreboard queue and corner-case sequences.
module tb_t02_bus_arbiter;

    localparam int NUM_REQ = 2;
`ifdef T02_ARB_TIMEOUT_EN
    localparam int TB_TIMEOUT = 8;
`else
    localparam int TB_TIMEOUT = 255;
`endif

    logic                  clk = 1'b0;
    logic                  rst, en;
    logic [NUM_REQ-1:0]    req_valid, req_we, req_ack;
    logic [32*NUM_REQ-1:0] req_addr, req_wdata;
    logic [4*NUM_REQ-1:0]  req_sel;
    logic [31:0]           req_rdata, mgr_adr, mgr_wdata, mgr_rdata;
    logic                  req_err, mgr_write, mgr_read, mgr_busy;
    logic [1:0]            grant_id;
    logic [3:0]            mgr_sel;

    typedef struct {
        int          idx;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic [31:0] rdata;
        int          busy;
    } txn_t;

    typedef struct {
        logic [1:0]  ack;
        logic [31:0] rdata;
        logic        err;
    } sb_t;

    sb_t         exp_q[$];
    txn_t        vecs[5];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] last_rdata;

    // Manager model configuration.
    bit          stuck;
    bit          use_tbl;
    int          busy_len;
    logic [31:0] tbl_rdata;
    int          mgr_left;

    t02_bus_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_sel   (req_sel),
        .req_ack   (req_ack),
        .req_rdata (req_rdata),
        .req_err   (req_err),
        .grant_id  (grant_id),
        .mgr_adr   (mgr_adr),
        .mgr_wdata (mgr_wdata),
        .mgr_sel   (mgr_sel),
        .mgr_write (mgr_write),
        .mgr_read  (mgr_read),
        .mgr_rdata (mgr_rdata),
        .mgr_busy  (mgr_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Manager: sees read/write at an edge, then holds busy for busy_len cycles.
    always @(posedge clk) begin
        if (rst) begin
            mgr_busy <= 1'b0;
            mgr_left <= 0;
        end else if (stuck) begin
            mgr_busy <= 1'b1;
        end else if (mgr_left > 0) begin
            mgr_busy <= 1'b1;
            mgr_left <= mgr_left - 1;
        end else if (!mgr_busy && (mgr_read || mgr_write)) begin
            mgr_busy  <= 1'b1;
            mgr_left  <= busy_len - 1;
            mgr_rdata <= use_tbl ? tbl_rdata : (mgr_adr ^ 32'hFFFF_0000);
        end else begin
            mgr_busy <= 1'b0;
        end
    end

    // Scoreboard and protocol invariants.
    logic prev_ack_nz = 1'b0;
    always @(negedge clk) begin
        sb_t e;
        if (rst) begin
            prev_ack_nz = 1'b0;
        end else begin
            check("rw_exclusive", 32'(mgr_read & mgr_write), 32'd0);
            if (req_ack != '0) begin
                check("ack_onehot", 32'($onehot0(req_ack)), 32'd1);
                check("ack_single_cycle", 32'(prev_ack_nz), 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 32'(req_ack), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_vec", 32'(req_ack), 32'(e.ack));
                    check("ack_rdata", req_rdata, e.rdata);
                    check("ack_err", 32'(req_err), 32'(e.err));
                end
            end
            prev_ack_nz = (req_ack != '0);
        end
    end

    task automatic set_req(input int idx, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] sel);
        if (idx == 0) begin
            req_we[0]       = we;
            req_addr[31:0]  = addr;
            req_wdata[31:0] = wdata;
            req_sel[3:0]    = sel;
        end else begin
            req_we[1]        = we;
            req_addr[63:32]  = addr;
            req_wdata[63:32] = wdata;
            req_sel[7:4]     = sel;
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ack_err_grant"}, 32'({req_ack, req_err, grant_id}), 32'd0);
        check({tag, "_rw_sel"}, 32'({mgr_read, mgr_write, mgr_sel}), 32'd0);
        check({tag, "_rdata"}, req_rdata, 32'd0);
        check({tag, "_adr"}, mgr_adr, 32'd0);
        check({tag, "_wdata"}, mgr_wdata, 32'd0);
    endtask

    // One isolated transaction; to=1 expects a timeout abort.
    task automatic do_txn(input txn_t t, input bit to);
        sb_t e;
        int  edges = 0;
        bit  got   = 1'b0;
        tbl_rdata = t.rdata;
        busy_len  = t.busy;
        e.ack     = (t.idx == 0) ? 2'b01 : 2'b10;
        e.rdata   = to ? 32'hDEAD_BEEF : (t.we ? last_rdata : t.rdata);
        e.err     = to;
        exp_q.push_back(e);
        last_rdata = e.rdata;
        @(posedge clk);
        #1;
        set_req(t.idx, t.we, t.addr, t.wdata, t.sel);
        req_valid = e.ack;
        while (!got && edges < 300) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (edges == 1) begin
                check("issue_rw", 32'({mgr_write, mgr_read}), t.we ? 32'd2 : 32'd1);
                check("issue_adr", mgr_adr, t.addr);
                check("issue_grant", 32'(grant_id), 32'(t.idx));
                if (t.we) begin
                    check("issue_wdata", mgr_wdata, t.wdata);
                    check("issue_sel", 32'(mgr_sel), 32'(t.sel));
                end
            end
            if (req_ack != '0) got = 1'b1;
        end
        check("ack_seen", 32'(got), 32'd1);
        check("ack_latency", 32'(edges), to ? 32'(TB_TIMEOUT + 1) : 32'(3 + t.busy));
        req_valid = '0;
    endtask

    initial begin
        int   seen;
        int   cyc;
        bit   got;
        sb_t  e;
        txn_t t_to;

        vecs[0] = '{0, 1'b0, 32'h3300_0010, 32'h0000_0000, 4'hF, 32'h1234_5678, 4};
        vecs[1] = '{1, 1'b1, 32'h3300_0020, 32'hA5A5_A5A5, 4'hF, 32'h0000_0000, 2};
        vecs[2] = '{1, 1'b0, 32'h3300_0024, 32'h0000_0000, 4'hF, 32'hCAFE_F00D, 1};
        vecs[3] = '{0, 1'b1, 32'h3300_0100, 32'h0000_00FF, 4'h1, 32'h0000_0000, 3};
        vecs[4] = '{0, 1'b0, 32'h3300_0108, 32'h0000_0000, 4'hF, 32'h89AB_CDEF, 6};

        rst       = 1'b1;
        en        = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_sel   = '0;
        stuck     = 1'b0;
        use_tbl   = 1'b0;
        busy_len  = 2;
        tbl_rdata = '0;
        mgr_rdata = '0;

        // Contention: both requesters held from reset; rr=0 so requester 1 wins first.
        set_req(0, 1'b0, 32'h0000_1000, 32'h0, 4'hF);
        set_req(1, 1'b0, 32'h0000_2000, 32'h0, 4'hF);
        req_valid = 2'b11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("reset");
        for (int k = 0; k < 4; k++) begin
            e.ack   = (k % 2 == 0) ? 2'b10 : 2'b01;
            e.rdata = (k % 2 == 0) ? 32'hFFFF_2000 : 32'hFFFF_1000;
            e.err   = 1'b0;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 0;
        cyc  = 0;
        while (seen < 4 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (req_ack != '0) seen++;
        end
        req_valid = '0;
        check("contention_acks", 32'(seen), 32'd4);
        last_rdata = 32'hFFFF_1000;

        use_tbl = 1'b1;
        foreach (vecs[i]) do_txn(vecs[i], 1'b0);

        // Enable low blocks grants; raising it grants on the next edge.
        @(posedge clk);
        #1;
        en        = 1'b0;
        tbl_rdata = 32'h0BAD_F00D;
        busy_len  = 2;
        set_req(0, 1'b0, 32'h3300_0200, 32'h0, 4'hF);
        req_valid = 2'b01;
        e.ack   = 2'b01;
        e.rdata = 32'h0BAD_F00D;
        e.err   = 1'b0;
        exp_q.push_back(e);
        last_rdata = 32'h0BAD_F00D;
        repeat (5) begin
            @(negedge clk);
            check("en_low_no_rw", 32'({mgr_read, mgr_write}), 32'd0);
        end
        @(posedge clk);
        #1 en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("en_high_read", 32'(mgr_read), 32'd1);
        check("en_high_grant", 32'(grant_id), 32'd0);
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (req_ack != '0) got = 1'b1;
        end
        check("en_ack_seen", 32'(got), 32'd1);
        req_valid = '0;

        // Reset while waiting on the manager: everything clears and no ack follows.
        @(posedge clk);
        #1;
        tbl_rdata = 32'h7777_7777;
        busy_len  = 6;
        set_req(1, 1'b0, 32'h3300_0300, 32'h0, 4'hF);
        req_valid = 2'b10;
        repeat (4) @(posedge clk);
        #1;
        check("pre_rst_grant", 32'(grant_id), 32'd1);
        check("pre_rst_adr", mgr_adr, 32'h3300_0300);
        rst       = 1'b1;
        req_valid = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_zero_outputs("rst_mid");
        repeat (10) @(negedge clk);
        last_rdata = 32'h0;

`ifdef T02_ARB_TIMEOUT_EN
        // Manager stuck busy: abort after TIMEOUT cycles with the error pattern.
        stuck = 1'b1;
        t_to  = '{1, 1'b0, 32'h3300_0400, 32'h0, 4'hF, 32'h0, 1};
        do_txn(t_to, 1'b1);
        stuck = 1'b0;
`else
        t_to  = '{1, 1'b0, 32'h3300_0400, 32'h0, 4'hF, 32'h5555_AAAA, 3};
        do_txn(t_to, 1'b0);
`endif

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
